// File: rtl/egress_pkg.sv
// ============================================================================
//  Package     : egress_pkg
//  Description : Shared widths, channel-index type and helpers for the egress
//                drain counter and its round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package egress_pkg;

  localparam int DATA_W = 10;
  localparam int TAG_W  = 2;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 5;

  // Saturation value of the per-channel transfer counters.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Channel index: 0..3 maps to FIFO 4..7.
  typedef logic [1:0] ch_idx_t;

  // Convert a one-hot channel vector into its index (0 when no bit is set).
  function automatic ch_idx_t onehot_to_idx(input logic [NUM_CH-1:0] oh);
    ch_idx_t r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) r = ch_idx_t'(i);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
//  Module      : rr_arbiter_4
//  Description : Four-way round-robin arbiter. Priority starts at the channel
//                after the last one granted; the pointer only moves when the
//                caller actually takes the grant.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4
  import egress_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  // Pointer resets to the last channel so the first grant goes to channel 0.
  localparam ch_idx_t LAST_RESET = 2'd3;

  ch_idx_t last;
  ch_idx_t cand;
  logic    found;

  // Scan the four channels starting just after the last grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = last + ch_idx_t'(i);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Remember the granted channel once the grant is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= LAST_RESET;
    end else if (advance && (grant != '0)) begin
      last <= onehot_to_idx(grant);
    end
  end

endmodule

`default_nettype wire

// File: rtl/egress_drain_counter.sv
// ============================================================================
//  Module      : egress_drain_counter
//  Description : Drains four output FIFOs (4..7) round-robin into a 2-entry
//                output buffer, counts transfers per channel with saturation,
//                serves counter reads, and flags destination-tag mismatches.
//                Optional build macro EGRESS_CLEAR_ON_READ_EN makes a counter
//                read clear the counter it returned.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module egress_drain_counter
  import egress_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] fifo4_out,
  input  logic [DATA_W-1:0] fifo5_out,
  input  logic [DATA_W-1:0] fifo6_out,
  input  logic [DATA_W-1:0] fifo7_out,
  input  logic              empty4,
  input  logic              empty5,
  input  logic              empty6,
  input  logic              empty7,
  output logic              pop4,
  output logic              pop5,
  output logic              pop6,
  output logic              pop7,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  chan_out,
  output logic              valid_out,
  input  logic              req,
  input  ch_idx_t           idx,
  output logic [CNT_W-1:0]  counter_out,
  output logic              counter_valid,
  output logic              err_dest
);

  logic [DATA_W-1:0] fifo_data [NUM_CH];
  logic [NUM_CH-1:0] empty_vec;
  logic [NUM_CH-1:0] pop_q;
  logic [NUM_CH-1:0] arb_req;
  logic [NUM_CH-1:0] grant;
  logic [2:0]        pending;
  logic              can_pop;

  logic              cap_valid;
  ch_idx_t           cap_ch;
  logic [DATA_W-1:0] cap_data;

  logic [DATA_W-1:0] buf_data [2];
  ch_idx_t           buf_ch   [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ;
  logic              xfer;

  logic [CNT_W-1:0]  count [NUM_CH];
  logic [NUM_CH-1:0] inc_vec;
  logic [NUM_CH-1:0] clr_vec;

  assign fifo_data[0] = fifo4_out;
  assign fifo_data[1] = fifo5_out;
  assign fifo_data[2] = fifo6_out;
  assign fifo_data[3] = fifo7_out;
  assign empty_vec    = {empty7, empty6, empty5, empty4};

  assign pop4 = pop_q[0];
  assign pop5 = pop_q[1];
  assign pop6 = pop_q[2];
  assign pop7 = pop_q[3];

  // Words already owned: buffered, popped this cycle, or arriving this cycle.
  // Staying below 2 guarantees a slot for every word that was popped.
  assign pending = {1'b0, occ} + {2'b00, |pop_q} + {2'b00, cap_valid};
  assign can_pop = (pending < 3'd2);

  // The FIFO being popped this cycle may go empty after the edge, so it is
  // never eligible for the very next pop.
  assign arb_req = ~empty_vec & ~pop_q;

  rr_arbiter_4 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (can_pop),
    .grant   (grant)
  );

  // Registered pop strobes: at most one, and only when a buffer slot is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q <= '0;
    end else begin
      pop_q <= can_pop ? grant : '0;
    end
  end

  // Read data arrives the cycle after a pop; remember which channel it is.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_ch    <= '0;
    end else begin
      cap_valid <= |pop_q;
      cap_ch    <= onehot_to_idx(pop_q);
    end
  end

  assign cap_data = fifo_data[cap_ch];

  assign valid_out = (occ != 2'd0);
  assign data_out  = buf_data[rd_ptr];
  assign chan_out  = buf_ch[rd_ptr];
  assign xfer      = valid_out && out_ready;

  // Two-entry output buffer; capture and transfer may happen together.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_ch[i]   <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (cap_valid) begin
        buf_data[wr_ptr] <= cap_data;
        buf_ch[wr_ptr]   <= cap_ch;
        wr_ptr           <= ~wr_ptr;
      end
      if (xfer) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({cap_valid, xfer})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Sticky flag: a captured word's tag does not name its own channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_dest <= 1'b0;
    end else if (cap_valid && (cap_data[DATA_W-1 -: TAG_W] != cap_ch)) begin
      err_dest <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_ctl
    assign inc_vec[g] = xfer && (chan_out == ch_idx_t'(g));
`ifdef EGRESS_CLEAR_ON_READ_EN
    assign clr_vec[g] = req && (idx == ch_idx_t'(g));
`else
    assign clr_vec[g] = 1'b0;
`endif
  end

  // Saturating per-channel transfer counters; a clearing read that meets a
  // same-channel transfer leaves the count at one.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_vec[i]) begin
          count[i] <= inc_vec[i] ? CNT_W'(1) : '0;
        end else if (inc_vec[i] && (count[i] != CNT_MAX)) begin
          count[i] <= count[i] + CNT_W'(1);
        end
      end
    end
  end

  // Counter read port: value sampled before this edge's increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_out   <= '0;
      counter_valid <= 1'b0;
    end else begin
      counter_valid <= req;
      if (req) begin
        counter_out <= count[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_egress_drain_counter.sv
// ============================================================================
//  Module      : tb_egress_drain_counter
//  Description : Scoreboard bench for egress_drain_counter with a behavioural
//                model of the four output FIFOs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_egress_drain_counter;
  import egress_pkg::*;

  typedef struct packed {
    logic [1:0] ch;
    logic [9:0] d;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] fifo_out [4];
  logic [3:0] empty;
  logic       pop4, pop5, pop6, pop7;
  logic [3:0] pop;
  logic       out_ready = 1'b0;
  logic [9:0] data_out;
  logic [1:0] chan_out;
  logic       valid_out;
  logic       req = 1'b0;
  logic [1:0] idx = 2'd0;
  logic [4:0] counter_out;
  logic       counter_valid;
  logic       err_dest;

  assign pop = {pop7, pop6, pop5, pop4};

  always #5 clk = ~clk;

  egress_drain_counter dut (
    .clk(clk), .reset(reset),
    .fifo4_out(fifo_out[0]), .fifo5_out(fifo_out[1]),
    .fifo6_out(fifo_out[2]), .fifo7_out(fifo_out[3]),
    .empty4(empty[0]), .empty5(empty[1]), .empty6(empty[2]), .empty7(empty[3]),
    .pop4(pop4), .pop5(pop5), .pop6(pop6), .pop7(pop7),
    .out_ready(out_ready),
    .data_out(data_out), .chan_out(chan_out), .valid_out(valid_out),
    .req(req), .idx(idx),
    .counter_out(counter_out), .counter_valid(counter_valid),
    .err_dest(err_dest)
  );

  // ---------------- FIFO model ----------------
  logic [9:0] q0[$], q1[$], q2[$], q3[$];
  logic [3:0] seen_pop;

  task automatic push_word(input int ch, input logic [9:0] w);
    case (ch)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  initial begin
    for (int i = 0; i < 4; i++) fifo_out[i] = '0;
    empty = 4'hF;
    forever begin
      @(negedge clk);
      seen_pop = pop;
      @(posedge clk);
      #1;
      if (seen_pop[0] && q0.size() > 0) fifo_out[0] = q0.pop_front();
      if (seen_pop[1] && q1.size() > 0) fifo_out[1] = q1.pop_front();
      if (seen_pop[2] && q2.size() > 0) fifo_out[2] = q2.pop_front();
      if (seen_pop[3] && q3.size() > 0) fifo_out[3] = q3.pop_front();
      empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    end
  end

  // ---------------- scoreboard / monitor ----------------
  item_t      exp_q[$];
  logic [4:0] cnt_q[$];
  int         pop_log[$];
  int         errors = 0;
  int         checks = 0;
  int         pop_seen = 0;
  item_t      mon_e;
  logic [4:0] mon_c;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_d;
  logic [1:0] prev_c;

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (($countones(pop) > 1) || ((pop & empty) != 4'd0)) begin
        errors++;
        $display("FAIL pop_legal: pop=%b empty=%b, required one-hot pop to non-empty", pop, empty);
      end
      if (pop != 4'd0) begin
        pop_seen++;
        pop_log.push_back(int'(onehot_to_idx(pop)));
      end
      if (prev_stall && valid_out) begin
        checks++;
        if (data_out !== prev_d || chan_out !== prev_c) begin
          errors++;
          $display("FAIL hold: got ch=%0d data=%h, required ch=%0d data=%h", chan_out, data_out, prev_c, prev_d);
        end
      end
      if (valid_out && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected: got ch=%0d data=%h, required no transfer", chan_out, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (chan_out !== mon_e.ch || data_out !== mon_e.d) begin
            errors++;
            $display("FAIL xfer: got ch=%0d data=%h, required ch=%0d data=%h", chan_out, data_out, mon_e.ch, mon_e.d);
          end
        end
      end
      if (counter_valid) begin
        checks++;
        if (cnt_q.size() == 0) begin
          errors++;
          $display("FAIL counter_unexpected: got %0d, required no counter_valid", counter_out);
        end else begin
          mon_c = cnt_q.pop_front();
          if (counter_out !== mon_c) begin
            errors++;
            $display("FAIL counter: got %0d, required %0d", counter_out, mon_c);
          end
        end
      end
      prev_stall = valid_out && !out_ready;
      prev_d     = data_out;
      prev_c     = chan_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] mkw(input int ch, input int k);
    logic [1:0] t;
    logic [7:0] lo;
    t  = 2'(ch);
    lo = 8'(ch * 16 + k + 1);
    return {t, lo};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    chk("rst_pop", {28'd0, pop}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_data", {22'd0, data_out}, 32'd0);
    chk("rst_chan", {30'd0, chan_out}, 32'd0);
    chk("rst_cnt_out", {27'd0, counter_out}, 32'd0);
    chk("rst_cnt_valid", {31'd0, counter_valid}, 32'd0);
    chk("rst_err", {31'd0, err_dest}, 32'd0);
    reset = 1'b0;
  endtask

  task automatic read_cnt(input int ch, input logic [4:0] exp);
    req = 1'b1;
    idx = 2'(ch);
    cnt_q.push_back(exp);
    cyc(1);
    req = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cnt_q.size() != 0) && n < budget) begin
      cyc(1);
      n++;
    end
    cyc(3);
    checks++;
    if (exp_q.size() != 0 || cnt_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d words %0d counts left, required 0", name, exp_q.size(), cnt_q.size());
      exp_q.delete();
      cnt_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int p0;
    int ok;
    cyc(1);
    do_reset();

    // All FIFOs empty: nothing moves, counts stay zero.
    out_ready = 1'b1;
    p0 = pop_seen;
    cyc(20);
    chk("idle_pops", 32'(pop_seen - p0), 32'd0);
    chk("idle_valid", {31'd0, valid_out}, 32'd0);
    for (int c = 0; c < 4; c++) read_cnt(c, 5'd0);
    wait_drain("idle", 20);

    // Two words per FIFO: strict rotation 4,5,6,7,4,5,6,7.
    do_reset();
    pop_log.delete();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++) begin
        push_word(c, mkw(c, k));
        exp_q.push_back({2'(c), mkw(c, k)});
      end
    wait_drain("rr", 200);
    chk("rr_pop_count", pop_log.size(), 32'd8);
    if (pop_log.size() == 8)
      for (int i = 0; i < 8; i++) chk("rr_pop_order", pop_log[i], 32'(i % 4));
    chk("rr_err", {31'd0, err_dest}, 32'd0);
    for (int c = 0; c < 4; c++) read_cnt(c, 5'd2);
    wait_drain("rr_cnt", 20);

    // Backpressure: only two pops while stalled, head held, nothing lost.
    do_reset();
    out_ready = 1'b0;
    p0 = pop_seen;
    push_word(0, mkw(0, 0)); push_word(0, mkw(0, 1));
    push_word(2, mkw(2, 0)); push_word(2, mkw(2, 1));
    exp_q.push_back({2'd0, mkw(0, 0)});
    exp_q.push_back({2'd2, mkw(2, 0)});
    exp_q.push_back({2'd0, mkw(0, 1)});
    exp_q.push_back({2'd2, mkw(2, 1)});
    cyc(12);
    chk("stall_pops", 32'(pop_seen - p0), 32'd2);
    chk("stall_valid", {31'd0, valid_out}, 32'd1);
    chk("stall_head", {22'd0, data_out}, {22'd0, mkw(0, 0)});
    chk("stall_chan", {30'd0, chan_out}, 32'd0);
    out_ready = 1'b1;
    wait_drain("stall", 200);

    // 35 transfers on channel 5: counter saturates at 31.
    do_reset();
    for (int k = 0; k < 35; k++) begin
      push_word(1, {2'b01, 8'(k)});
      exp_q.push_back({2'd1, {2'b01, 8'(k)}});
    end
    wait_drain("sat", 600);
    read_cnt(1, 5'd31);
`ifdef EGRESS_CLEAR_ON_READ_EN
    read_cnt(1, 5'd0);
`else
    read_cnt(1, 5'd31);
`endif
    read_cnt(0, 5'd0);
    wait_drain("sat_cnt", 20);

    // Bad tag from fifo4: sticky error until reset.
    do_reset();
    chk("err_before", {31'd0, err_dest}, 32'd0);
    push_word(0, 10'b11_0101_1010);
    exp_q.push_back({2'd0, 10'b11_0101_1010});
    wait_drain("err", 100);
    chk("err_set", {31'd0, err_dest}, 32'd1);
    push_word(1, mkw(1, 3));
    exp_q.push_back({2'd1, mkw(1, 3)});
    wait_drain("err2", 100);
    chk("err_sticky", {31'd0, err_dest}, 32'd1);
    do_reset();
    chk("err_cleared", {31'd0, err_dest}, 32'd0);

    // Reset right after a pop: the in-flight word is discarded.
    push_word(0, mkw(0, 7));
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      cyc(1);
      if (pop4) ok = 1;
    end
    chk("mid_pop_seen", 32'(ok), 32'd1);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    p0 = pop_seen;
    chk("mid_valid0", {31'd0, valid_out}, 32'd0);
    cyc(10);
    chk("mid_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_pops", 32'(pop_seen - p0), 32'd0);
    read_cnt(0, 5'd0);
    wait_drain("mid", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/egress_drain_counter.md
EGRESS_DRAIN_COUNTER -- requirements
Module: egress_drain_counter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: fifo4_out..fifo7_out  input  10 each  output-FIFO read data; bits[9:8] are the destination tag.
REQ-004 SHALL have ports: empty4..empty7  input  1 each  output-FIFO empty flags.
REQ-005 SHALL have ports: pop4..pop7  output  1 each  registered pop strobes to the output FIFOs.
REQ-006 SHALL have ports: out_ready  input  1  downstream accepts a word this cycle.
REQ-007 SHALL have ports: data_out  output  10, chan_out  output  2, valid_out  output  1  drained word, source channel, qualifier.
REQ-008 SHALL have ports: req  input  1, idx  input  2  counter read request and channel select.
REQ-009 SHALL have ports: counter_out  output  5, counter_valid  output  1  requested count and 1-cycle qualifier.
REQ-010 SHALL have port: err_dest  output  1  sticky tag-mismatch flag.

Function
REQ-011 SHALL assert at most one popN per cycle, never to a FIFO whose emptyN is high in that cycle.
REQ-012 SHALL select among non-empty channels round-robin, starting after the last granted channel; first grant after reset goes to channel 4.
REQ-013 SHALL treat FIFO read data as valid in the cycle after popN is high, and capture it with its channel into a 2-entry output buffer on that cycle's edge.
REQ-014 SHALL have a minimum latency of 2 cycles from pop to valid_out, given an empty buffer and out_ready high.
REQ-015 SHALL issue a pop only when buffer occupancy plus in-flight pops is less than 2, so no word is ever dropped.
REQ-016 SHALL present the buffer head on data_out/chan_out with valid_out high while the buffer is non-empty; a word transfers when valid_out and out_ready are both high.
REQ-017 SHALL hold data_out/chan_out stable while valid_out is high and out_ready is low.
REQ-018 SHALL keep a 5-bit count per channel, increment it on each transfer from that channel, and saturate it at 31 (no wrap).
REQ-019 SHALL, when req is high at edge N, drive counter_out = count[idx] and counter_valid = 1 in cycle N+1; counter_valid SHALL be 0 otherwise and counter_out SHALL hold its last value.
REQ-020 SHALL return the pre-increment value when req and a transfer on the same channel coincide.
REQ-021 SHALL set err_dest when a captured word's bits[9:8] differ from (channel-4); err_dest SHALL clear only on reset.
REQ-022 SHALL allow a simultaneous capture and transfer in one cycle with occupancy unchanged.

Reset
REQ-023 SHALL, while reset is high, drive pop4..pop7=0, valid_out=0, data_out=0, chan_out=0, counter_out=0, counter_valid=0, err_dest=0, clear the buffer and all counts, and point round-robin to channel 4.
REQ-024 SHALL discard in-flight pop data when reset is asserted mid-operation; the first pop after reset release SHALL occur no earlier than the cycle after release.

Configuration
REQ-025 SHALL, with EGRESS_CLEAR_ON_READ_EN defined, clear count[idx] when a req is served; a coinciding same-channel transfer SHALL leave that count at 1.
REQ-026 SHALL, without EGRESS_CLEAR_ON_READ_EN, leave counts unaffected by reads.

Structure
REQ-027 SHALL take DATA_W=10, TAG_W=2, NUM_CH=4, CNT_W=5 and the channel-index type from shared package egress_pkg.
REQ-028 SHALL implement round-robin selection in sub-module rr_arbiter_4 (4-bit request, one-hot grant, pointer advanced on grant).

Verification
REQ-029 Bench SHALL cover: empty4..7=1 throughout -> no pop, valid_out stays 0, counts stay 0.
REQ-030 Bench SHALL cover: all four FIFOs hold 2 words, out_ready=1 -> pop order 4,5,6,7,4,5,6,7; chan_out follows that order; every count reads 2.
REQ-031 Bench SHALL cover: out_ready=0 for 10 cycles with data pending -> exactly 2 pops issued, data_out held, no loss after out_ready returns to 1.
REQ-032 Bench SHALL cover: 35 transfers from channel 5 with req=1, idx=1 -> counter_out=31, and =0 on an immediate re-read with EGRESS_CLEAR_ON_READ_EN defined.
REQ-033 Bench SHALL cover: word 10'b11_xxxxxxxx drained from fifo4 -> err_dest=1 until reset.
REQ-034 Bench SHALL cover: reset pulsed one cycle after a pop -> valid_out=0 and counts=0 afterwards, and the stale word is never output.
